// File: rtl/key_expand.sv
// AES key-schedule generator: expands a 128/192/256-bit cipher key one 32-bit word
// per clock into a 60-word schedule, repacked as the 1920-bit round-key bus.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        logic [7:0] yy;
        p  = 8'h00;
        xx = x;
        yy = y;
        for (int k = 0; k < 8; k++) begin
            if (yy[0]) begin
                p = p ^ xx;
            end else begin
                p = p;
            end
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
            yy = {1'b0, yy[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    logic [7:0] b_s;

    // Inverse followed by the AES affine transform
    always_comb begin
        b_s = gf_inv(a);
        s   = b_s ^ {b_s[6:0], b_s[7]} ^ {b_s[5:0], b_s[7:6]}
                  ^ {b_s[4:0], b_s[7:5]} ^ {b_s[3:0], b_s[7:4]} ^ 8'h63;
    end

endmodule

module key_expand (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [255:0]    key_in,
    input  logic [1:0]      switch,
    input  logic            start,
    output logic [1919:0]   key_d,
    output logic            key_valid,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state_q, state_d;
    logic [5:0]   nk_q, nk_d;
    logic [3:0]   nr_q, nr_d;
    logic [5:0]   i_q, i_d;
    logic [2:0]   j_q, j_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  w_q [0:59];
    logic [31:0]  w_d [0:59];
    logic         key_valid_q, key_valid_d;
    logic         busy_q, busy_d;

    logic [31:0]  prev_s, old_s, rot_s, sub_in_s, sub_s, t_s;
    logic [7:0]   rcon_next_s;
    logic [5:0]   last_idx_s;

    assign prev_s      = w_q[i_q - 6'd1];
    assign old_s       = w_q[i_q - nk_q];
    assign rot_s       = {prev_s[23:0], prev_s[31:24]};
    assign sub_in_s    = (j_q == 3'd0) ? rot_s : prev_s;
    assign rcon_next_s = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    assign last_idx_s  = {nr_q, 2'b11};

    aes_sbox u_sbox3 (.a(sub_in_s[31:24]), .s(sub_s[31:24]));
    aes_sbox u_sbox2 (.a(sub_in_s[23:16]), .s(sub_s[23:16]));
    aes_sbox u_sbox1 (.a(sub_in_s[15:8]),  .s(sub_s[15:8]));
    aes_sbox u_sbox0 (.a(sub_in_s[7:0]),   .s(sub_s[7:0]));

    // Select the recurrence term for the word being generated
    always_comb begin
        t_s = prev_s;
        if (j_q == 3'd0) begin
            t_s = sub_s ^ {rcon_q, 24'h000000};
        end else if ((nk_q == 6'd8) && (j_q == 3'd4)) begin
            t_s = sub_s;
        end else begin
            t_s = prev_s;
        end
    end

    // Next-state logic for the controller and the word store
    always_comb begin
        logic [5:0]   nk_new;
        logic [3:0]   nr_new;
        logic [255:0] mask;
        logic [255:0] kmask;
        state_d     = state_q;
        nk_d        = nk_q;
        nr_d        = nr_q;
        i_d         = i_q;
        j_d         = j_q;
        rcon_d      = rcon_q;
        w_d         = w_q;
        key_valid_d = key_valid_q;
        busy_d      = busy_q;
        nk_new      = 6'd8;
        nr_new      = 4'd14;
        mask        = {256{1'b1}};
        kmask       = 256'h0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    case (switch)
                        2'b00: begin
                            nk_new = 6'd4;
                            nr_new = 4'd10;
                            mask   = {{128{1'b1}}, {128{1'b0}}};
                        end
                        2'b01: begin
                            nk_new = 6'd6;
                            nr_new = 4'd12;
                            mask   = {{192{1'b1}}, {64{1'b0}}};
                        end
                        default: begin
                            nk_new = 6'd8;
                            nr_new = 4'd14;
                            mask   = {256{1'b1}};
                        end
                    endcase
                    kmask       = key_in & mask;
                    w_d         = '{default: 32'h0};
                    w_d[0]      = kmask[255:224];
                    w_d[1]      = kmask[223:192];
                    w_d[2]      = kmask[191:160];
                    w_d[3]      = kmask[159:128];
                    w_d[4]      = kmask[127:96];
                    w_d[5]      = kmask[95:64];
                    w_d[6]      = kmask[63:32];
                    w_d[7]      = kmask[31:0];
                    nk_d        = nk_new;
                    nr_d        = nr_new;
                    i_d         = nk_new;
                    j_d         = 3'd0;
                    rcon_d      = 8'h01;
                    key_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = EXPAND;
                end else begin
                    state_d = state_q;
                end
            end
            EXPAND: begin
                w_d[i_q] = old_s ^ t_s;
                i_d      = i_q + 6'd1;
                if ({3'b000, j_q} == (nk_q - 6'd1)) begin
                    j_d = 3'd0;
                end else begin
                    j_d = j_q + 3'd1;
                end
                if (j_q == 3'd0) begin
                    rcon_d = rcon_next_s;
                end else begin
                    rcon_d = rcon_q;
                end
                if (i_q == last_idx_s) begin
                    state_d     = DONE;
                    key_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = EXPAND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nk_q        <= 6'd0;
            nr_q        <= 4'd0;
            i_q         <= 6'd0;
            j_q         <= 3'd0;
            rcon_q      <= 8'h00;
            w_q         <= '{default: 32'h0};
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nk_q        <= nk_d;
            nr_q        <= nr_d;
            i_q         <= i_d;
            j_q         <= j_d;
            rcon_q      <= rcon_d;
            w_q         <= w_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Round 0 is shifted in first so round Nr lands in the lowest slot
    always_comb begin
        logic [1919:0] acc;
        logic [5:0]    idx;
        logic [3:0]    rr;
        acc = 1920'h0;
        idx = 6'd0;
        rr  = 4'd0;
        for (int r = 0; r < 15; r++) begin
            if (rr <= nr_q) begin
                acc = {acc[1791:0], w_q[idx], w_q[idx + 6'd1], w_q[idx + 6'd2], w_q[idx + 6'd3]};
            end else begin
                acc = acc;
            end
            idx = idx + 6'd4;
            rr  = rr + 4'd1;
        end
        key_d = acc;
    end

    assign key_valid = key_valid_q;
    assign busy      = busy_q;

endmodule

// File: doc/key_expand.md
# key_expand

Sequential AES key-schedule generator feeding the encryption datapath. Accepts a 128/192/256-bit cipher key plus the 2-bit key-size select and produces one 32-bit schedule word per clock. Its output is the packed 1920-bit round-key bus (`key_d`), laid out exactly as the round controller indexes it. A `key_valid` level tells the encrypt stage when the schedule is complete and stable.

## Interface
- No parameters. Nb = 4 fixed. Nk/Nr derived from `switch`.
- `clk` in 1: single clock, all state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `key_in` in 256: cipher key, left-aligned.
  - 128-bit key in [255:128]; 192-bit key in [255:64]; 256-bit key uses all bits.
  - w[0] = most-significant word; unused low bits ignored.
- `switch` in 2: key size. 00 → Nk=4, Nr=10; 01 → Nk=6, Nr=12; 10/11 → Nk=8, Nr=14.
- `start` in 1: request expansion; sampled only when not busy.
- `key_d` out 1920: packed round keys.
  - Round key r (0..Nr) occupies bits [(Nr+1-r)*128-1 -: 128], with w[4r] in the top word.
  - Round 0 is the highest used slot; round Nr is [127:0]; bits above (Nr+1)*128 read 0.
- `key_valid` out 1: schedule complete and stable.
- `busy` out 1: expansion in progress.

## Operation
- Storage: 60 × 32-bit word registers w[0..59]. `Nk`/`Nr` are latched from `switch` on start; `key_d` is a combinational repack of w[] using the latched Nr.
- States:
  - IDLE: reset state.
  - EXPAND: generating words.
  - DONE: schedule complete; holds indefinitely.
- IDLE or DONE with `start`=1:
  - Latch Nk/Nr.
  - Load w[0..Nk-1] from `key_in`; clear w[Nk..59] to 0.
  - Set i=Nk, j=0 (i mod Nk), rcon=8'h01.
  - Clear `key_valid`, set `busy`; go to EXPAND.
- EXPAND, each cycle write w[i] = w[i-Nk] ^ t, where t is:
  - j==0: SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon ← xtime(rcon) (0x80→0x1B).
  - Nk==8 and j==4: SubWord(w[i-1]).
  - Otherwise: w[i-1].
  - Then i++, j = (j==Nk-1) ? 0 : j+1. No divider is used.
- RotWord: {b1,b2,b3,b0}. SubWord: four instances of the shared byte S-box module, combinational.
- The cycle that writes the last word w[4(Nr+1)-1]: go to DONE, `key_valid`←1, `busy`←0.
- `start` while in EXPAND is ignored. `switch`/`key_in` changes after start have no effect until the next start.
- `start` in DONE restarts: `key_valid` drops on that same edge.
- Reset (`rst_n`=0 at a clock edge, any state including mid-expansion):
  - State IDLE; all w[] = 0, so `key_d` = 0.
  - `key_valid`=0, `busy`=0; i, j, rcon cleared.

## Timing
- Start edge E0 loads the key. Words are written on edges E1..E(4(Nr+1)-Nk).
- `key_valid` and `busy` change on the last write edge:
  - 128-bit: 40 edges after E0.
  - 192-bit: 46 edges after E0.
  - 256-bit: 52 edges after E0.
- `busy` is high from E0 through the last write edge, exclusive of that edge's update.
- `key_d` holds partial values while `busy`=1. The consumer must not sample it before `key_valid`=1.
- `key_d` is stable for as long as `key_valid`=1.
- Reset values: `key_d`=0, `key_valid`=0, `busy`=0.

## Test plan
- 128-bit, `switch`=00, key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - `key_valid` rises exactly 40 cycles after start.
  - `key_d[127:0]` = d014f9a8c9ee2589e13f0cc8b6630ca6; `key_d[1407:1280]` = key; `key_d[1919:1408]` = 0.
- 192-bit, `switch`=01, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - `key_valid` rises at 46 cycles.
  - `key_d[127:0]` = e98ba06f448c773c8ecc720401002202.
- 256-bit, `switch`=10, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - `key_valid` rises at 52 cycles.
  - `key_d[127:0]` = fe4890d1e6188d0b046df344706c631e.
  - Repeating with `switch`=11 gives an identical result.
- Start pulse mid-expansion (cycle 20 of the 128-bit run) is ignored: result and latency are unchanged.
- Start from DONE with a new key:
  - `key_valid` drops on the start edge.
  - The new schedule is valid 40 cycles later.
- `rst_n`=0 at cycle 25 of a 256-bit run:
  - Next edge: `key_d`=0, `busy`=0, `key_valid`=0.
  - A subsequent start completes normally with the correct vector.
